// File: rtl/jtag_debug_cmd_sysclk.sv
`timescale 1ns/1ps
// JTAG debug command bridge: synchronises TCK-domain update strobes into clk, queues {IR, DR} commands, pops to one-hot pulses.
// Latency: strobe edge cycle E -> cmd_valid at E+1 -> action pulse at E+2 with cmd_ready held high.
// Backpressure: cmd_ready stalls the queue; a push into a full queue with no pop is dropped and sets sticky overflow.
// Optional JTAG_DBG_DROP_COUNT_EN adds a saturating 8-bit drop_count output.
module jtag_debug_cmd_sysclk #(
    parameter int SR_W        = 38,
    parameter int IR_W        = 2,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int ACT_BIT     = 34
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     vs_udr,
    input  logic                     vs_uir,
    input  logic [IR_W-1:0]          ir_in,
    input  logic [SR_W-1:0]          sr,
    input  logic                     cmd_ready,
    input  logic                     overflow_clr,
    output logic                     cmd_valid,
    output logic [SR_W-1:0]          jdo,
    output logic [IR_W-1:0]          cmd_ir,
    output logic [(2**IR_W)-1:0]     take_action,
    output logic [(2**IR_W)-1:0]     take_no_action,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     overflow
`ifdef JTAG_DBG_DROP_COUNT_EN
    ,
    output logic [7:0]               drop_count
`endif
);

    localparam int NCH = 2**IR_W;
    localparam int AW  = $clog2(DEPTH);
    localparam int CW  = AW + 1;
    localparam int EW  = IR_W + SR_W;

    logic [SYNC_STAGES-1:0] udr_sync;
    logic [SYNC_STAGES-1:0] uir_sync;
    logic                   udr_hist;
    logic                   uir_hist;
    logic [SYNC_STAGES:0]   warm;
    logic                   udr_edge;
    logic                   uir_edge;

    logic [IR_W-1:0]        ir_lat;
    logic [EW-1:0]          mem [DEPTH];
    logic [AW-1:0]          wr_ptr;
    logic [AW-1:0]          rd_ptr;
    logic [EW-1:0]          head;
    logic [NCH-1:0]         head_onehot;
    logic [CW-1:0]          count_nxt;
    logic                   full;
    logic                   pop;
    logic                   push_ok;
    logic                   drop;

    // warm fills once the synchronisers and history hold real samples, so a
    // strobe already high when reset releases is not seen as a fresh edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            udr_sync <= '0;
            uir_sync <= '0;
            udr_hist <= 1'b0;
            uir_hist <= 1'b0;
            warm     <= '0;
        end else begin
            udr_sync <= {udr_sync[SYNC_STAGES-2:0], vs_udr};
            uir_sync <= {uir_sync[SYNC_STAGES-2:0], vs_uir};
            udr_hist <= udr_sync[SYNC_STAGES-1];
            uir_hist <= uir_sync[SYNC_STAGES-1];
            warm     <= {warm[SYNC_STAGES-1:0], 1'b1};
        end
    end

    assign udr_edge = udr_sync[SYNC_STAGES-1] & ~udr_hist & warm[SYNC_STAGES];
    assign uir_edge = uir_sync[SYNC_STAGES-1] & ~uir_hist & warm[SYNC_STAGES];

    // A coincident DR push still sees the pre-update latch value.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ir_lat <= '0;
        end else if (uir_edge) begin
            ir_lat <= ir_in;
        end
    end

    assign full    = (fifo_count == CW'(DEPTH));
    assign pop     = cmd_valid & cmd_ready;
    assign push_ok = udr_edge & (~full | pop);
    assign drop    = udr_edge & full & ~pop;

    always_comb begin
        count_nxt = fifo_count + CW'(push_ok) - CW'(pop);
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= {ir_lat, sr};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            cmd_valid  <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            fifo_count <= count_nxt;
            cmd_valid  <= (count_nxt != '0);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (overflow_clr) begin
            overflow <= 1'b0;
        end
    end

    assign head        = mem[rd_ptr];
    assign head_onehot = {{(NCH-1){1'b0}}, 1'b1} << head[EW-1:SR_W];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            jdo            <= '0;
            cmd_ir         <= '0;
            take_action    <= '0;
            take_no_action <= '0;
        end else if (pop) begin
            jdo            <= head[SR_W-1:0];
            cmd_ir         <= head[EW-1:SR_W];
            take_action    <= head[ACT_BIT] ? head_onehot : '0;
            take_no_action <= head[ACT_BIT] ? '0 : head_onehot;
        end else begin
            take_action    <= '0;
            take_no_action <= '0;
        end
    end

`ifdef JTAG_DBG_DROP_COUNT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            drop_count <= 8'd0;
        end else if (overflow_clr) begin
            drop_count <= drop ? 8'd1 : 8'd0;
        end else if (drop && (drop_count != 8'hFF)) begin
            drop_count <= drop_count + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_jtag_debug_cmd_sysclk.sv
`timescale 1ns/1ps
// Randomised bench for jtag_debug_cmd_sysclk against a transaction-level queue model.
module tb_jtag_debug_cmd_sysclk;

    localparam int SR_W  = 38;
    localparam int IR_W  = 2;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [3:0]  ta;
        logic [3:0]  tn;
        logic [1:0]  ir;
        logic [37:0] w;
    } pulse_t;

    logic              clk;
    logic              reset_n;
    logic              vs_udr;
    logic              vs_uir;
    logic [IR_W-1:0]   ir_in;
    logic [SR_W-1:0]   sr;
    logic              cmd_ready;
    logic              overflow_clr;
    logic              cmd_valid;
    logic [SR_W-1:0]   jdo;
    logic [IR_W-1:0]   cmd_ir;
    logic [3:0]        take_action;
    logic [3:0]        take_no_action;
    logic [2:0]        fifo_count;
    logic              overflow;
`ifdef JTAG_DBG_DROP_COUNT_EN
    logic [7:0]        drop_count;
`endif

    jtag_debug_cmd_sysclk dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .vs_udr         (vs_udr),
        .vs_uir         (vs_uir),
        .ir_in          (ir_in),
        .sr             (sr),
        .cmd_ready      (cmd_ready),
        .overflow_clr   (overflow_clr),
        .cmd_valid      (cmd_valid),
        .jdo            (jdo),
        .cmd_ir         (cmd_ir),
        .take_action    (take_action),
        .take_no_action (take_no_action),
        .fifo_count     (fifo_count),
        .overflow       (overflow)
`ifdef JTAG_DBG_DROP_COUNT_EN
        ,
        .drop_count     (drop_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int      n_checks = 0;
    int      n_errors = 0;
    pulse_t  obs[$];
    pulse_t  exp_q[$];
    int      occ = 0;
    logic    m_ovf = 1'b0;
    int      m_drops = 0;
    logic [1:0] cur_ir = 2'd0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset_n && (take_action != 4'd0 || take_no_action != 4'd0))
            obs.push_back('{ta: take_action, tn: take_no_action, ir: cmd_ir, w: jdo});
    end

    function automatic pulse_t mk(input logic [1:0] ir, input logic [37:0] w);
        pulse_t     p;
        logic [3:0] oh;
        oh   = 4'b0001 << ir;
        p.ta = w[34] ? oh : 4'd0;
        p.tn = w[34] ? 4'd0 : oh;
        p.ir = ir;
        p.w  = w;
        return p;
    endfunction

    task automatic model_push(input logic [37:0] w);
        if (occ < DEPTH) begin
            exp_q.push_back(mk(cur_ir, w));
            occ++;
        end else begin
            m_ovf = 1'b1;
            if (m_drops < 255) m_drops++;
        end
    endtask

    task automatic pulse_uir(input logic [1:0] ir);
        @(negedge clk);
        ir_in  = ir;
        vs_uir = 1'b1;
        repeat (3) @(negedge clk);
        vs_uir = 1'b0;
        repeat (4) @(negedge clk);
        cur_ir = ir;
    endtask

    task automatic pulse_udr(input logic [37:0] w);
        @(negedge clk);
        sr = w;
        @(negedge clk);
        vs_udr = 1'b1;
        repeat (3) @(negedge clk);
        vs_udr = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic drain_and_compare(input string tag);
        cmd_ready = 1'b1;
        repeat (DEPTH + 4) @(negedge clk);
        cmd_ready = 1'b0;
        occ = 0;
        check({tag, "_npulse"}, obs.size(), exp_q.size());
        for (int i = 0; i < obs.size() && i < exp_q.size(); i++)
            check({tag, "_pulse"}, obs[i], exp_q[i]);
        check({tag, "_empty"}, fifo_count, 0);
        obs.delete();
        exp_q.delete();
    endtask

    task automatic clear_overflow();
        @(negedge clk);
        overflow_clr = 1'b1;
        @(negedge clk);
        overflow_clr = 1'b0;
        m_ovf   = 1'b0;
        m_drops = 0;
        check("ovf_clr", overflow, 0);
`ifdef JTAG_DBG_DROP_COUNT_EN
        check("drops_clr", drop_count, 0);
`endif
    endtask

    // Steps cycle by cycle from the strobe rise: edge cycle is after the second
    // sampling clock, so valid shows after the third and the pulse after the fourth.
    task automatic single_cmd(input logic [1:0] ir, input logic [37:0] w,
                              input logic [3:0] ea, input logic [3:0] en);
        pulse_uir(ir);
        cmd_ready = 1'b1;
        @(negedge clk);
        sr     = w;
        vs_udr = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk);
            #1;
            check("lat_ta", take_action, (k == 4) ? ea : 4'd0);
            check("lat_tn", take_no_action, (k == 4) ? en : 4'd0);
            check("lat_valid", cmd_valid, (k == 3));
            if (k == 4) begin
                check("lat_jdo", jdo, w);
                check("lat_ir", cmd_ir, ir);
            end
        end
        @(negedge clk);
        vs_udr = 1'b0;
        repeat (4) @(negedge clk);
        cmd_ready = 1'b0;
        obs.delete();
    endtask

    initial begin
        logic [37:0] w;
        logic [1:0]  nir;
        int          k;

        reset_n = 1'b0; vs_udr = 1'b0; vs_uir = 1'b0; ir_in = '0; sr = '0;
        cmd_ready = 1'b0; overflow_clr = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_valid", cmd_valid, 0);
        check("rst_count", fifo_count, 0);
        check("rst_ovf", overflow, 0);
        check("rst_ta", take_action, 0);
        check("rst_tn", take_no_action, 0);
        check("rst_jdo", jdo, 0);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);

        single_cmd(2'd2, 38'h4_0000_0123, 4'b0100, 4'b0000);
        single_cmd(2'd1, 38'h0_0000_0456, 4'b0000, 4'b0010);

        // Overflow: five pushes into a four-deep queue with the consumer stalled.
        for (int i = 1; i <= 5; i++) begin
            pulse_udr(38'(i));
            model_push(38'(i));
        end
        check("ovf_count", fifo_count, 4);
        check("ovf_flag", overflow, 1);
        check("ovf_valid", cmd_valid, 1);
`ifdef JTAG_DBG_DROP_COUNT_EN
        check("ovf_drops", drop_count, m_drops);
`endif
        drain_and_compare("ovf");
        check("ovf_sticky", overflow, 1);
        clear_overflow();

        // Full queue with a pop landing in the push edge cycle.
        for (int i = 0; i < 4; i++) begin
            pulse_udr(38'h4_0000_0010 + 38'(i));
            model_push(38'h4_0000_0010 + 38'(i));
        end
        @(negedge clk);
        sr = 38'h0_0000_0015;
        @(negedge clk);
        vs_udr = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        cmd_ready = 1'b1;
        @(posedge clk);
        #1;
        check("pp_ovf", overflow, 0);
        check("pp_count", fifo_count, 4);
        @(negedge clk);
        cmd_ready = 1'b0;
        vs_udr    = 1'b0;
        occ--;
        model_push(38'h0_0000_0015);
        repeat (4) @(negedge clk);
        check("pp_ovf2", overflow, 0);
        check("pp_count2", fifo_count, 4);
        drain_and_compare("pp");

        // Coincident IR and DR updates: the push takes the old channel.
        nir = cur_ir + 2'd1;
        w   = 38'h4_0000_0777;
        @(negedge clk);
        sr = w; ir_in = nir;
        @(negedge clk);
        vs_uir = 1'b1; vs_udr = 1'b1;
        repeat (3) @(negedge clk);
        vs_uir = 1'b0; vs_udr = 1'b0;
        repeat (4) @(negedge clk);
        model_push(w);
        cur_ir = nir;
        drain_and_compare("coin");

        for (int it = 0; it < 20; it++) begin
            k = $urandom_range(1, 6);
            for (int j = 0; j < k; j++) begin
                if ($urandom_range(0, 1) == 1)
                    pulse_uir(2'($urandom_range(0, 3)));
                w = {6'($urandom_range(0, 63)), 32'($urandom)};
                pulse_udr(w);
                model_push(w);
            end
            check("rnd_count", fifo_count, occ);
            check("rnd_ovf", overflow, m_ovf);
            check("rnd_valid", cmd_valid, (occ != 0));
`ifdef JTAG_DBG_DROP_COUNT_EN
            check("rnd_drops", drop_count, m_drops);
`endif
            drain_and_compare("rnd");
            if (m_ovf) clear_overflow();
        end

        // Reset with three commands queued, strobe held high through release.
        for (int i = 0; i < 3; i++) begin
            w = {6'($urandom_range(0, 63)), 32'($urandom)};
            pulse_udr(w);
        end
        check("mid_count", fifo_count, 3);
        @(negedge clk);
        reset_n = 1'b0;
        vs_udr  = 1'b1;
        #1;
        check("mid_valid", cmd_valid, 0);
        check("mid_cnt0", fifo_count, 0);
        check("mid_ta", take_action, 0);
        check("mid_tn", take_no_action, 0);
        check("mid_jdo", jdo, 0);
        check("mid_ir", cmd_ir, 0);
        check("mid_ovf", overflow, 0);
        @(negedge clk);
        reset_n   = 1'b1;
        cmd_ready = 1'b1;
        obs.delete();
        repeat (12) @(negedge clk);
        check("post_npulse", obs.size(), 0);
        check("post_count", fifo_count, 0);
        check("post_valid", cmd_valid, 0);
        vs_udr    = 1'b0;
        cmd_ready = 1'b0;
        repeat (4) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
